// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, divider FSM encoding and
// the quotient pattern reported on a zero divisor.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic [ALU_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div8b_subnb.sv
// Parameterized ripple-borrow subtractor d = x - y; b_out is the borrow out
// of the MSB, i.e. high when y > x.
module subnb #(
    parameter int N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] d,
    output logic         b_out
);

    always_comb begin
        logic bb;
        bb    = 1'b0;
        d     = '0;
        for (int i = 0; i < N; i++) begin
            d[i] = x[i] ^ y[i] ^ bb;
            bb   = (~x[i] & y[i]) | (~x[i] & bb) | (y[i] & bb);
        end
        b_out = bb;
    end

endmodule

// File: rtl/div8b.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock,
// with a start/done handshake and divide-by-zero flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands latched on acceptance
// RUN     | one trial subtraction per cycle, W iterations
// DONE    | results loaded; emits the one-cycle done pulse on exit
module div8b
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         start,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    div_state_e     state;
    logic [W-1:0]   dq;
    logic [W-1:0]   dv;
    logic [W:0]     pr;
    logic [CW-1:0]  cnt;

    logic [W:0]     t;
    logic [W:0]     d;
    logic           borrow;
    logic [W:0]     pr_next;
    logic [W-1:0]   dq_next;
    logic           unused_pr_msb;

    // The partial remainder stays below the divisor, so its MSB never feeds t.
    assign unused_pr_msb = pr[W];

    assign t = {pr[W-1:0], dq[W-1]};

    subnb #(.N(W + 1)) u_sub (
        .x     (t),
        .y     ({1'b0, dv}),
        .d     (d),
        .b_out (borrow)
    );

    assign pr_next = borrow ? t : d;
    assign dq_next = {dq[W-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dq       <= '0;
            dv       <= '0;
            pr       <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (y != '0) begin
                            dq       <= x;
                            dv       <= y;
                            pr       <= '0;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_RUN;
                        end else begin
                            q        <= W'(DIV_ZERO_Q);
                            r        <= x;
                            div_zero <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    pr  <= pr_next;
                    dq  <= dq_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        q     <= dq_next;
                        r     <= pr_next[W-1:0];
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div8b.sv
// Directed and random checks for the div8b sequential divider.
module tb_div8b;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;
    logic       start;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    div8b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .start    (start),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Issue a request; returns just after the accepting edge.
    task automatic start_div(input logic [7:0] xv, input logic [7:0] yv);
        x     = xv;
        y     = yv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // lat counts edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    int lat;
    int bcnt;
    logic [7:0] xv;
    logic [7:0] yv;

    initial begin
        rst_n = 1'b0;
        x     = '0;
        y     = '0;
        start = 1'b0;
        tick();
        tick();
        check("rst_q",        q,        0);
        check("rst_r",        r,        0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        tick();

        // 15 / 3
        start_div(8'b00001111, 8'b00000011);
        wait_done(lat, bcnt);
        check("t1_latency", lat, 9);
        check("t1_busy_cycles", bcnt, 8);
        check("t1_q", q, 5);
        check("t1_r", r, 0);
        check("t1_div_zero", div_zero, 0);
        tick();
        check("t1_done_one_cycle", done, 0);
        check("t1_q_held", q, 5);

        start_div(8'd255, 8'd16);
        wait_done(lat, bcnt);
        check("t2_q", q, 15);
        check("t2_r", r, 15);
        start_div(8'd3, 8'd200);
        wait_done(lat, bcnt);
        check("t3_q", q, 0);
        check("t3_r", r, 3);

        // divide by zero: done right after the edge following acceptance
        start_div(8'd7, 8'd0);
        wait_done(lat, bcnt);
        check("dz_latency", lat, 1);
        check("dz_busy_cycles", bcnt, 0);
        check("dz_q", q, 8'hFF);
        check("dz_r", r, 7);
        check("dz_flag", div_zero, 1);
        tick();
        check("dz_flag_held", div_zero, 1);
        check("dz_q_held", q, 8'hFF);
        start_div(8'd10, 8'd2);
        check("dz_cleared_on_start", div_zero, 0);
        wait_done(lat, bcnt);
        check("t4_q", q, 5);
        check("t4_r", r, 0);

        // start held high with new operands through RUN and DONE
        x     = 8'd100;
        y     = 8'd7;
        start = 1'b1;
        tick();
        x = 8'd9;
        y = 8'd3;
        wait_done(lat, bcnt);
        check("hold_latency", lat, 9);
        check("hold_q", q, 14);
        check("hold_r", r, 2);
        tick();
        start = 1'b0;
        check("hold_reaccept_busy", busy, 1);
        wait_done(lat, bcnt);
        check("hold2_latency", lat, 9);
        check("hold2_q", q, 3);
        check("hold2_r", r, 0);

        // reset during the 4th RUN cycle
        start_div(8'd100, 8'd7);
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_q",        q,        0);
        check("mid_rst_r",        r,        0);
        check("mid_rst_busy",     busy,     0);
        check("mid_rst_done",     done,     0);
        check("mid_rst_div_zero", div_zero, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_idle_busy", busy, 0);
        start_div(8'd200, 8'd9);
        wait_done(lat, bcnt);
        check("post_rst_latency", lat, 9);
        check("post_rst_q", q, 22);
        check("post_rst_r", r, 2);

        // random sweep against the arithmetic identity
        for (int i = 0; i < 1000; i++) begin
            xv = 8'($urandom_range(255, 0));
            yv = 8'($urandom_range(255, 1));
            start_div(xv, yv);
            wait_done(lat, bcnt);
            check("rand_q", q, 32'(xv / yv));
            check("rand_r", r, 32'(xv % yv));
            check("rand_identity", 32'(q) * 32'(yv) + 32'(r), 32'(xv));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
